// File: rtl/hc_pkg.sv
// Shared types and width helpers for the parametrised Huffman code generator.
package hc_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_INIT,
    ST_WALK,
    ST_DONE
  } hc_state_t;

  function automatic int id_w(input int nsym);
    return $clog2(2 * nsym - 1);
  endfunction

  function automatic int len_w(input int maxlen);
    return $clog2(maxlen + 1);
  endfunction

  // Internal node index width; held at 1 so a two-symbol tree still has a port.
  function automatic int waddr_w(input int nsym);
    return (nsym > 2) ? $clog2(nsym - 1) : 1;
  endfunction

  function automatic int code_w(input int maxlen);
    return len_w(maxlen) + maxlen;
  endfunction

endpackage

// File: rtl/huffman_codegen_p_if.sv
// Node-load / start / code-read bus between tree builder, code generator and encoder.
interface huffman_codegen_p_if #(
  parameter int NSYM   = 10,
  parameter int MAXLEN = 9
);
  import hc_pkg::*;

  localparam int ID_W   = id_w(NSYM);
  localparam int WA_W   = waddr_w(NSYM);
  localparam int RA_W   = $clog2(NSYM);
  localparam int CODE_W = code_w(MAXLEN);

  logic                Start_code;
  logic [ID_W-1:0]     Root;
  logic                Node_we;
  logic [WA_W-1:0]     Node_waddr;
  logic [2*ID_W-1:0]   Node_wdata;
  logic [RA_W-1:0]     Code_raddr;
  logic [CODE_W-1:0]   Code_rdata;
  logic                Busy;
  logic                Fin;
  logic                Err;

  modport master (
    output Start_code, Root, Node_we, Node_waddr, Node_wdata, Code_raddr,
    input  Code_rdata, Busy, Fin, Err
  );

  modport slave (
    input  Start_code, Root, Node_we, Node_waddr, Node_wdata, Code_raddr,
    output Code_rdata, Busy, Fin, Err
  );

endinterface

// File: rtl/hc_lifo.sv
// Parametrised LIFO with show-ahead top entry; push+pop together replaces the top.
module hc_lifo #(
  parameter int DEPTH = 9,
  parameter int WIDTH = 8
) (
  input  logic             Clk_in,
  input  logic             n_Rst,
  input  logic             clr,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);
  localparam int PW = $clog2(DEPTH + 1);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    sp;
  logic [AW-1:0]    top_idx;
  logic             replace;

  assign empty   = (sp == '0);
  assign full    = (sp == PW'(DEPTH));
  assign top_idx = AW'(sp - PW'(1));
  assign rdata   = empty ? '0 : mem[top_idx];
  assign replace = push && pop && !empty;

  always_ff @(posedge Clk_in or negedge n_Rst) begin
    if (!n_Rst)                 sp <= '0;
    else if (clr)               sp <= '0;
    else if (replace)           sp <= sp;
    else if (push && !full)     sp <= sp + PW'(1);
    else if (pop && !empty)     sp <= sp - PW'(1);
  end

  always_ff @(posedge Clk_in) begin
    if (!clr && push) begin
      if (replace)    mem[top_idx] <= wdata;
      else if (!full) mem[AW'(sp)] <= wdata;
    end
  end

endmodule

// File: rtl/huffman_codegen_p.sv
// Huffman code generator: depth-first tree walk with an explicit LIFO into a code table.
// Build option HC_COVER_EN adds a visited map that flags duplicate and missing leaves.
//
// state | meaning
// IDLE  | waiting for Start_code; Fin/Err hold the last result
// INIT  | root is a leaf -> single 1-bit code, else start walking
// WALK  | one node per cycle: descend left / emit leaf and pop
// DONE  | (optional coverage check) then raise Fin, back to IDLE
module huffman_codegen_p
  import hc_pkg::*;
#(
  parameter int NSYM   = 10,
  parameter int MAXLEN = 9
) (
  input logic                 Clk_in,
  input logic                 n_Rst,
  huffman_codegen_p_if.slave  bus
);
  localparam int ID_W   = id_w(NSYM);
  localparam int LEN_W  = len_w(MAXLEN);
  localparam int CODE_W = code_w(MAXLEN);
  localparam int WA_W   = waddr_w(NSYM);
  localparam int RA_W   = $clog2(NSYM);
  localparam int NINT   = NSYM - 1;

  localparam logic [ID_W-1:0]  NSYM_ID = ID_W'(NSYM);
  localparam logic [ID_W-1:0]  MAX_ID  = ID_W'(2 * NSYM - 2);
  localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(MAXLEN);

  typedef struct packed {
    logic [ID_W-1:0]   id;
    logic [MAXLEN-1:0] pfx;
    logic [LEN_W-1:0]  len;
  } stk_ent_t;

  hc_state_t         state, state_n;
  logic [ID_W-1:0]   cur, cur_n;
  logic [MAXLEN-1:0] pfx, pfx_n;
  logic [LEN_W-1:0]  len, len_n;
  logic              err, err_n, fin, fin_n;
  logic              busy;

  logic [2*ID_W-1:0] node_ram [NINT];
  logic [CODE_W-1:0] code_tab [NSYM];
  logic [CODE_W-1:0] code_q, tab_wdata;
  logic [2*ID_W-1:0] node_rd;
  logic [ID_W-1:0]   child_l, child_r;
  logic [RA_W-1:0]   sym_idx;
  logic              tab_we, tab_clr, stk_push, stk_pop, stk_full, stk_empty;
  stk_ent_t          push_ent, top_ent;

`ifdef HC_COVER_EN
  logic [NSYM-1:0]   visited, visited_n;
  logic              chk_done, chk_done_n;
`endif

  assign busy               = (state == ST_INIT) || (state == ST_WALK);
  assign sym_idx            = RA_W'(cur);
  assign node_rd            = node_ram[WA_W'(cur - NSYM_ID)];
  assign {child_l, child_r} = node_rd;

  assign bus.Busy       = busy;
  assign bus.Fin        = fin;
  assign bus.Err        = err;
  assign bus.Code_rdata = code_q;

  // Written in the Start_code cycle too, so the walk already sees the new node.
  always_ff @(posedge Clk_in) begin
    if (bus.Node_we && !busy && ({1'b0, bus.Node_waddr} < (WA_W + 1)'(NINT)))
      node_ram[bus.Node_waddr] <= bus.Node_wdata;
  end

  hc_lifo #(
    .DEPTH (MAXLEN),
    .WIDTH ($bits(stk_ent_t))
  ) u_lifo (
    .Clk_in (Clk_in),
    .n_Rst  (n_Rst),
    .clr    (tab_clr),
    .push   (stk_push),
    .pop    (stk_pop),
    .wdata  (push_ent),
    .rdata  (top_ent),
    .full   (stk_full),
    .empty  (stk_empty)
  );

  always_comb begin
    state_n   = state;
    cur_n     = cur;
    pfx_n     = pfx;
    len_n     = len;
    err_n     = err;
    fin_n     = fin;
    tab_we    = 1'b0;
    tab_clr   = 1'b0;
    tab_wdata = {len, pfx};
    stk_push  = 1'b0;
    stk_pop   = 1'b0;
    push_ent  = '{id: child_r, pfx: pfx << 1, len: len + LEN_W'(1)};
`ifdef HC_COVER_EN
    visited_n  = visited;
    chk_done_n = chk_done;
`endif
    unique case (state)
      ST_IDLE: begin
        if (bus.Start_code) begin
          cur_n   = bus.Root;
          pfx_n   = '0;
          len_n   = '0;
          err_n   = 1'b0;
          fin_n   = 1'b0;
          tab_clr = 1'b1;
          state_n = ST_INIT;
`ifdef HC_COVER_EN
          visited_n  = '0;
          chk_done_n = 1'b0;
`endif
        end
      end
      ST_INIT: begin
        if (cur < NSYM_ID) begin
          tab_we    = 1'b1;
          tab_wdata = {LEN_W'(1), MAXLEN'(1)};
          state_n   = ST_DONE;
`ifdef HC_COVER_EN
          visited_n[sym_idx] = 1'b1;
`endif
        end else begin
          state_n = ST_WALK;
        end
      end
      ST_WALK: begin
        if (cur > MAX_ID) begin
          err_n   = 1'b1;
          state_n = ST_DONE;
        end else if (cur >= NSYM_ID) begin
          if (child_l > MAX_ID || child_r > MAX_ID || len >= LEN_MAX || stk_full) begin
            err_n   = 1'b1;
            state_n = ST_DONE;
          end else begin
            stk_push = 1'b1;
            cur_n    = child_l;
            pfx_n    = (pfx << 1) | MAXLEN'(1);
            len_n    = len + LEN_W'(1);
          end
        end else begin
          tab_we = 1'b1;
          if (stk_empty) begin
            state_n = ST_DONE;
          end else begin
            stk_pop = 1'b1;
            cur_n   = top_ent.id;
            pfx_n   = top_ent.pfx;
            len_n   = top_ent.len;
          end
`ifdef HC_COVER_EN
          visited_n[sym_idx] = 1'b1;
          if (visited[sym_idx]) begin
            tab_we  = 1'b0;
            stk_pop = 1'b0;
            err_n   = 1'b1;
            state_n = ST_DONE;
          end
`endif
        end
      end
      ST_DONE: begin
`ifdef HC_COVER_EN
        if (!chk_done) begin
          chk_done_n = 1'b1;
          if (!(&visited)) err_n = 1'b1;
        end else begin
          fin_n   = 1'b1;
          state_n = ST_IDLE;
        end
`else
        fin_n   = 1'b1;
        state_n = ST_IDLE;
`endif
      end
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge Clk_in or negedge n_Rst) begin
    if (!n_Rst) begin
      state <= ST_IDLE;
      cur   <= '0;
      pfx   <= '0;
      len   <= '0;
      err   <= 1'b0;
      fin   <= 1'b0;
`ifdef HC_COVER_EN
      visited  <= '0;
      chk_done <= 1'b0;
`endif
    end else begin
      state <= state_n;
      cur   <= cur_n;
      pfx   <= pfx_n;
      len   <= len_n;
      err   <= err_n;
      fin   <= fin_n;
`ifdef HC_COVER_EN
      visited  <= visited_n;
      chk_done <= chk_done_n;
`endif
    end
  end

  always_ff @(posedge Clk_in or negedge n_Rst) begin
    if (!n_Rst) begin
      for (int i = 0; i < NSYM; i++) code_tab[i] <= '0;
      code_q <= '0;
    end else begin
      if (tab_clr) begin
        for (int i = 0; i < NSYM; i++) code_tab[i] <= '0;
      end else if (tab_we) begin
        code_tab[sym_idx] <= tab_wdata;
      end
      code_q <= ({1'b0, bus.Code_raddr} < (RA_W + 1)'(NSYM)) ? code_tab[bus.Code_raddr] : '0;
    end
  end

endmodule

// File: tb/tb_huffman_codegen_p.sv
// Directed bench: 4-symbol tree, 10-symbol chain at MAXLEN 9 and 8, leaf root, bad child, reset abort.
module tb_huffman_codegen_p;

`ifdef HC_COVER_EN
  localparam int COV = 1;
`else
  localparam int COV = 0;
`endif

  logic Clk_in = 1'b0;
  logic n_Rst  = 1'b0;
  int   n_err  = 0;
  int   n_chk  = 0;

  always #5 Clk_in = ~Clk_in;

  huffman_codegen_p_if #(.NSYM(4),  .MAXLEN(9)) bus4   ();
  huffman_codegen_p_if #(.NSYM(10), .MAXLEN(9)) bus10  ();
  huffman_codegen_p_if #(.NSYM(10), .MAXLEN(8)) bus10s ();

  huffman_codegen_p #(.NSYM(4),  .MAXLEN(9)) u_dut4   (.Clk_in(Clk_in), .n_Rst(n_Rst), .bus(bus4.slave));
  huffman_codegen_p #(.NSYM(10), .MAXLEN(9)) u_dut10  (.Clk_in(Clk_in), .n_Rst(n_Rst), .bus(bus10.slave));
  huffman_codegen_p #(.NSYM(10), .MAXLEN(8)) u_dut10s (.Clk_in(Clk_in), .n_Rst(n_Rst), .bus(bus10s.slave));

  // The short-MAXLEN instance sees exactly the same stimulus as bus10.
  assign bus10s.Start_code = bus10.Start_code;
  assign bus10s.Root       = bus10.Root;
  assign bus10s.Node_we    = bus10.Node_we;
  assign bus10s.Node_waddr = bus10.Node_waddr;
  assign bus10s.Node_wdata = bus10.Node_wdata;
  assign bus10s.Code_raddr = bus10.Code_raddr;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk_in);
    #1;
  endtask

  task automatic wr4(input int idx, input int l, input int r);
    bus4.Node_we    = 1'b1;
    bus4.Node_waddr = 2'(idx);
    bus4.Node_wdata = {3'(l), 3'(r)};
    tick();
    bus4.Node_we    = 1'b0;
  endtask

  task automatic wr10(input int idx, input int l, input int r);
    bus10.Node_we    = 1'b1;
    bus10.Node_waddr = 4'(idx);
    bus10.Node_wdata = {5'(l), 5'(r)};
    tick();
    bus10.Node_we    = 1'b0;
  endtask

  task automatic rd4(input int sym, output int code);
    bus4.Code_raddr = 2'(sym);
    tick();
    code = int'(bus4.Code_rdata);
  endtask

  task automatic rd10(input int sym, output int code);
    bus10.Code_raddr = 4'(sym);
    tick();
    code = int'(bus10.Code_rdata);
  endtask

  // Start a walk, optionally pulse a stray Start_code at edge glitch_k, count edges to Fin.
  task automatic run4(input int root, input int glitch_k, output int fin_k, output int busy_k);
    bus4.Root       = 3'(root);
    bus4.Start_code = 1'b1;
    tick();
    bus4.Start_code = 1'b0;
    bus4.Node_we    = 1'b0;
    busy_k = int'(bus4.Busy);
    fin_k  = 0;
    for (int k = 1; k <= 100; k++) begin
      tick();
      if (bus4.Busy) busy_k++;
      if (bus4.Fin) begin
        fin_k = k;
        break;
      end
      if (k == glitch_k) begin
        bus4.Root       = 3'd0;
        bus4.Start_code = 1'b1;
      end else begin
        bus4.Start_code = 1'b0;
      end
    end
    bus4.Start_code = 1'b0;
    chk("fin4_seen", bus4.Fin, 1);
  endtask

  task automatic run10(input int root, output int fin_k, output int busy_k);
    bus10.Root       = 5'(root);
    bus10.Start_code = 1'b1;
    tick();
    bus10.Start_code = 1'b0;
    busy_k = int'(bus10.Busy);
    fin_k  = 0;
    for (int k = 1; k <= 100; k++) begin
      tick();
      if (bus10.Busy) busy_k++;
      if (bus10.Fin) begin
        fin_k = k;
        break;
      end
    end
    chk("fin10_seen", bus10.Fin, 1);
  endtask

  int fk, bk, code;
  int exp4_a [4] = '{1027, 1026, 1025, 1024};
  int exp4_b [4] = '{1025, 1024, 1027, 1026};

  initial begin
    bus4.Start_code  = 1'b0; bus4.Root  = '0; bus4.Node_we  = 1'b0;
    bus4.Node_waddr  = '0;   bus4.Node_wdata  = '0; bus4.Code_raddr  = '0;
    bus10.Start_code = 1'b0; bus10.Root = '0; bus10.Node_we = 1'b0;
    bus10.Node_waddr = '0;   bus10.Node_wdata = '0; bus10.Code_raddr = '0;

    repeat (3) @(posedge Clk_in);
    #1;
    chk("rst_busy", bus4.Busy, 0);
    chk("rst_fin",  bus4.Fin, 0);
    chk("rst_err",  bus4.Err, 0);
    chk("rst_code", bus4.Code_rdata, 0);
    n_Rst = 1'b1;
    tick();

    // balanced 4-symbol tree
    wr4(0, 0, 1); wr4(1, 2, 3); wr4(2, 4, 5);
    run4(6, 0, fk, bk);
    chk("t4_fin_lat", fk, 9 + COV);
    chk("t4_busy_cyc", bk, 8);
    chk("t4_err", bus4.Err, 0);
    for (int s = 0; s < 4; s++) begin
      rd4(s, code);
      chk($sformatf("t4_sym%0d", s), code, exp4_a[s]);
    end

    // node write in the Start_code cycle swaps the root children
    bus4.Node_we    = 1'b1;
    bus4.Node_waddr = 2'd2;
    bus4.Node_wdata = {3'd5, 3'd4};
    run4(6, 0, fk, bk);
    for (int s = 0; s < 4; s++) begin
      rd4(s, code);
      chk($sformatf("wr_start_sym%0d", s), code, exp4_b[s]);
    end
    wr4(2, 4, 5);

    // stray Start_code mid-walk with a leaf root must be ignored
    run4(6, 3, fk, bk);
    chk("ign_fin_lat", fk, 9 + COV);
    chk("ign_err", bus4.Err, 0);
    rd4(0, code); chk("ign_sym0", code, 1027);
    rd4(3, code); chk("ign_sym3", code, 1024);

    // left-skewed 10-symbol chain
    for (int k = 0; k < 8; k++) wr10(k, k + 11, k);
    wr10(8, 9, 8);
    run10(10, fk, bk);
    chk("chain_fin_lat", fk, 21 + COV);
    chk("chain_busy_cyc", bk, 20);
    chk("chain_err", bus10.Err, 0);
    rd10(0, code); chk("chain_sym0", code, 512);
    rd10(3, code); chk("chain_sym3", code, 2062);
    rd10(8, code); chk("chain_sym8", code, 5118);
    rd10(9, code); chk("chain_sym9", code, 5119);
    chk("short_err", bus10s.Err, 1);
    chk("short_fin", bus10s.Fin, 1);
    chk("short_busy", bus10s.Busy, 0);

    // single-symbol tree
    run10(3, fk, bk);
    chk("leaf_fin_lat", fk, 2 + COV);
    chk("leaf_busy_cyc", bk, 1);
    chk("leaf_err", bus10.Err, COV);
    rd10(3, code); chk("leaf_sym3", code, 513);
    rd10(0, code); chk("leaf_sym0", code, 0);
    rd10(9, code); chk("leaf_sym9", code, 0);

    // out-of-range child id
    wr10(0, 31, 0);
    run10(10, fk, bk);
    chk("badid_err", bus10.Err, 1);
    chk("badid_busy", bus10.Busy, 0);
    wr10(0, 11, 0);

    // reset in the middle of the chain walk, after leaf 9 has been written
    bus10.Root       = 5'd10;
    bus10.Start_code = 1'b1;
    tick();
    bus10.Start_code = 1'b0;
    repeat (14) tick();
    chk("mid_busy", bus10.Busy, 1);
    n_Rst = 1'b0;
    #1;
    chk("abort_busy", bus10.Busy, 0);
    chk("abort_fin",  bus10.Fin, 0);
    chk("abort_code", bus10.Code_rdata, 0);
    tick();
    n_Rst = 1'b1;
    rd10(9, code); chk("abort_sym9", code, 0);
    run10(10, fk, bk);
    chk("rerun_err", bus10.Err, 0);
    rd10(3, code); chk("rerun_sym3", code, 2062);
    rd10(9, code); chk("rerun_sym9", code, 5119);

    // leaf 2 reached twice, leaf 5 never
    wr10(5, 16, 2);
    run10(10, fk, bk);
`ifdef HC_COVER_EN
    chk("dup_err", bus10.Err, 1);
`else
    chk("dup_err", bus10.Err, 0);
    rd10(2, code); chk("dup_sym2", code, 1542);
    rd10(5, code); chk("dup_sym5", code, 0);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
